// File: rtl/lsfsm_pkg.sv
// Shared definitions for the lab CPU load/store control FSM: state codes, opcodes,
// branch condition codes, flag bit positions and the instruction-class decoder.
package lsfsm_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_STORE  = 3'd3,
    S_LOAD   = 3'd4,
    S_DOUT   = 3'd5,
    S_BRANCH = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_STOR,
    C_LOAD,
    C_BRANCH,
    C_WAIT,
    C_RTYPE,
    C_ITYPE
  } iclass_t;

  localparam logic [7:0] OP_WAIT  = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_ADDU  = 8'h06;
  localparam logic [7:0] OP_ADDC  = 8'h07;
  localparam logic [7:0] OP_RSH   = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;
  localparam logic [7:0] OP_SUBC  = 8'h0A;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_MOV   = 8'h0D;
  localparam logic [7:0] OP_MUL   = 8'h0E;
  localparam logic [7:0] OP_ARSH  = 8'h0F;
  localparam logic [7:0] OP_LSH   = 8'h8C;
  localparam logic [7:0] OP_ADDI  = 8'h50;
  localparam logic [7:0] OP_ADDUI = 8'h60;
  localparam logic [7:0] OP_SUBI  = 8'h90;
  localparam logic [7:0] OP_CMPI  = 8'hB0;
  localparam logic [7:0] OP_MOVI  = 8'hD0;
  localparam logic [7:0] OP_LOAD  = 8'h40;
  localparam logic [7:0] OP_STOR  = 8'h44;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  // Class priority matters: LOAD/STOR share the 0100 prefix, WAIT overlaps R-type.
  function automatic iclass_t classify(input logic [15:0] ir);
    iclass_t c;
    if (ir[15:12] == 4'h4 && ir[7:4] == 4'h4)      c = C_STOR;
    else if (ir[15:12] == 4'h4 && ir[7:4] == 4'h0) c = C_LOAD;
    else if (ir[15:12] == 4'hC)                    c = C_BRANCH;
    else if ({ir[15:12], ir[7:4]} == 8'h00)        c = C_WAIT;
    else if (ir[15:12] == 4'h0 || ir[15:12] == 4'h8) c = C_RTYPE;
    else                                           c = C_ITYPE;
    return c;
  endfunction

endpackage

// File: rtl/lsfsm_if.sv
// Control bus between the load/store FSM (master) and the CPU datapath (slave).
interface lsfsm_if;
  logic [15:0] instr_set;
  logic [4:0]  Flags_in;
  logic [15:0] wEnable;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_select;
  logic [3:0]  Rsrc_select;
  logic [15:0] Imm_in;
  logic        Imm_select;
  logic        we_a;
  logic        en_a;
  logic        en_b;
  logic        ram_wen;
  logic        lsc_mux_selct;
  logic [7:0]  pc_add_k;
  logic        pc_mux_selct;
  logic        pc_en;
  logic        fsm_alu_mem_selct;
  logic        decoder_en;

  modport master (
    input  instr_set, Flags_in,
    output wEnable, opcode, Rdest_select, Rsrc_select, Imm_in, Imm_select,
           we_a, en_a, en_b, ram_wen, lsc_mux_selct, pc_add_k, pc_mux_selct,
           pc_en, fsm_alu_mem_selct, decoder_en
  );

  modport slave (
    output instr_set, Flags_in,
    input  wEnable, opcode, Rdest_select, Rsrc_select, Imm_in, Imm_select,
           we_a, en_a, en_b, ram_wen, lsc_mux_selct, pc_add_k, pc_mux_selct,
           pc_en, fsm_alu_mem_selct, decoder_en
  );
endinterface

// File: rtl/lsfsm_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the ALU flags to a taken bit.
module lsfsm_cond_eval
  import lsfsm_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [4:0] i_flags,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken =  i_flags[FLAG_Z];
      COND_NE: o_taken = !i_flags[FLAG_Z];
      COND_CS: o_taken =  i_flags[FLAG_C];
      COND_CC: o_taken = !i_flags[FLAG_C];
      COND_HI: o_taken =  i_flags[FLAG_L];
      COND_LS: o_taken = !i_flags[FLAG_L];
      COND_GT: o_taken =  i_flags[FLAG_N];
      COND_LE: o_taken = !i_flags[FLAG_N];
      COND_FS: o_taken =  i_flags[FLAG_F];
      COND_FC: o_taken = !i_flags[FLAG_F];
      COND_LO: o_taken = !i_flags[FLAG_L] && !i_flags[FLAG_Z];
      COND_HS: o_taken =  i_flags[FLAG_L] ||  i_flags[FLAG_Z];
      COND_LT: o_taken = !i_flags[FLAG_N] && !i_flags[FLAG_Z];
      COND_GE: o_taken =  i_flags[FLAG_N] ||  i_flags[FLAG_Z];
      COND_UC: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_fsm.sv
// Multi-cycle fetch/decode/execute/load/store/branch controller for the 16-bit lab CPU.
// Define LSFSM_WAIT_HALT_EN to make WAIT halt (no PC advance) instead of acting as a NOP.
module load_store_fsm
  import lsfsm_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  lsfsm_if.master bus
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  iclass_t     w_class;
  iclass_t     w_dec_class;
  logic [7:0]  w_iop;
  logic [7:0]  w_opcode;
  logic        w_taken;
  logic        w_no_write;

  // Transitions out of DECODE use the live RAM word; IR only holds it from EXEC onward.
  assign w_class     = classify(r_ir);
  assign w_dec_class = classify(bus.instr_set);
  assign w_iop       = {r_ir[15:12], 4'h0};
  assign w_opcode    = (w_class == C_ITYPE || w_class == C_BRANCH) ? w_iop
                                                                   : {r_ir[15:12], r_ir[7:4]};
  assign w_no_write  = (w_class == C_WAIT) || (w_opcode == OP_CMP) || (w_opcode == OP_CMPI);

  lsfsm_cond_eval u_cond (
    .i_cond  (r_ir[11:8]),
    .i_flags (bus.Flags_in),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_ir <= bus.instr_set;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_dec_class)
          C_STOR:   w_next = S_STORE;
          C_LOAD:   w_next = S_LOAD;
          C_BRANCH: w_next = S_BRANCH;
          default:  w_next = S_EXEC;
        endcase
      end
      S_LOAD:   w_next = S_DOUT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.wEnable           = '0;
    bus.opcode            = w_opcode;
    bus.Rdest_select      = r_ir[11:8];
    bus.Rsrc_select       = r_ir[3:0];
    bus.Imm_in            = (w_iop == OP_MOVI || w_iop == OP_ADDUI) ? {8'h00, r_ir[7:0]}
                                                                    : {{8{r_ir[7]}}, r_ir[7:0]};
    bus.Imm_select        = 1'b0;
    bus.we_a              = 1'b0;
    bus.en_a              = 1'b0;
    bus.en_b              = 1'b0;
    bus.ram_wen           = 1'b0;
    bus.lsc_mux_selct     = 1'b0;
    bus.pc_add_k          = '0;
    bus.pc_mux_selct      = 1'b0;
    bus.pc_en             = 1'b0;
    bus.fsm_alu_mem_selct = 1'b0;
    bus.decoder_en        = 1'b0;
    case (r_state)
      S_FETCH:  bus.en_a = 1'b1;
      S_DECODE: begin
        bus.en_a       = 1'b1;
        bus.decoder_en = 1'b1;
      end
      S_EXEC: begin
        if (!w_no_write) bus.wEnable = 16'h0001 << r_ir[11:8];
        bus.Imm_select = (w_class == C_ITYPE);
`ifdef LSFSM_WAIT_HALT_EN
        bus.pc_en      = (w_class != C_WAIT);
`else
        bus.pc_en      = 1'b1;
`endif
      end
      S_STORE: begin
        bus.lsc_mux_selct = 1'b1;
        bus.en_a          = 1'b1;
        bus.we_a          = 1'b1;
        bus.ram_wen       = 1'b1;
        bus.pc_en         = 1'b1;
      end
      S_LOAD: begin
        bus.lsc_mux_selct = 1'b1;
        bus.en_a          = 1'b1;
      end
      S_DOUT: begin
        bus.lsc_mux_selct     = 1'b1;
        bus.fsm_alu_mem_selct = 1'b1;
        bus.wEnable           = 16'h0001 << r_ir[11:8];
        bus.pc_en             = 1'b1;
      end
      S_BRANCH: begin
        bus.pc_en        = 1'b1;
        bus.pc_add_k     = r_ir[7:0];
        bus.pc_mux_selct = w_taken;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_fsm.sv
// Directed, table-driven bench for load_store_fsm; honours LSFSM_WAIT_HALT_EN for WAIT expectations.
module tb_load_store_fsm;

  localparam logic [9:0] ENA    = 10'h200;
  localparam logic [9:0] WEA    = 10'h100;
  localparam logic [9:0] ENB    = 10'h080;
  localparam logic [9:0] RWEN   = 10'h040;
  localparam logic [9:0] LSC    = 10'h020;
  localparam logic [9:0] PCMUX  = 10'h010;
  localparam logic [9:0] PCEN   = 10'h008;
  localparam logic [9:0] MEMSEL = 10'h004;
  localparam logic [9:0] IMMSEL = 10'h002;
  localparam logic [9:0] DEC    = 10'h001;
`ifdef LSFSM_WAIT_HALT_EN
  localparam logic [9:0] WAIT_CTL = 10'h000;
`else
  localparam logic [9:0] WAIT_CTL = PCEN;
`endif

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [4:0]  flags;
    bit          isLoad;
    logic [9:0]  ctl;
    logic [15:0] wen;
    logic [7:0]  opc;
    logic [15:0] imm;
    logic [7:0]  k;
    logic [3:0]  rd;
    logic [3:0]  rs;
  } vec_t;

  logic clock;
  logic reset;
  int   nCompared;
  int   nMismatched;
  vec_t vecs[$];

  lsfsm_if bus();

  load_store_fsm dut (
    .clk   (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [9:0] getCtl();
    return {bus.en_a, bus.we_a, bus.en_b, bus.ram_wen, bus.lsc_mux_selct,
            bus.pc_mux_selct, bus.pc_en, bus.fsm_alu_mem_selct, bus.Imm_select,
            bus.decoder_en};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at a negedge while the FSM sits in FETCH; leaves it back in FETCH.
  task automatic applyStimulus(input vec_t v);
    bus.instr_set = v.instr;
    bus.Flags_in  = v.flags;
    #1;
    checkOutput({v.name, " fetch ctl"}, 16'(getCtl()), 16'(ENA));
    checkOutput({v.name, " fetch wEnable"}, bus.wEnable, 16'h0000);
    @(negedge clock);
    checkOutput({v.name, " decode ctl"}, 16'(getCtl()), 16'(ENA | DEC));
    @(posedge clock);
    #1 bus.instr_set = 16'hFFFF;
    @(negedge clock);
    if (v.isLoad) begin
      checkOutput({v.name, " load ctl"}, 16'(getCtl()), 16'(ENA | LSC));
      checkOutput({v.name, " load wEnable"}, bus.wEnable, 16'h0000);
      @(negedge clock);
    end
    checkOutput({v.name, " ctl"}, 16'(getCtl()), 16'(v.ctl));
    checkOutput({v.name, " wEnable"}, bus.wEnable, v.wen);
    checkOutput({v.name, " opcode"}, 16'(bus.opcode), 16'(v.opc));
    checkOutput({v.name, " Imm_in"}, bus.Imm_in, v.imm);
    checkOutput({v.name, " pc_add_k"}, 16'(bus.pc_add_k), 16'(v.k));
    checkOutput({v.name, " Rdest"}, 16'(bus.Rdest_select), 16'(v.rd));
    checkOutput({v.name, " Rsrc"}, 16'(bus.Rsrc_select), 16'(v.rs));
    @(negedge clock);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset         = 1'b0;
    bus.instr_set = 16'h0000;
    bus.Flags_in  = 5'h00;

    vecs.push_back('{"ADDI",   16'h5105, 5'h00, 1'b0, PCEN | IMMSEL, 16'h0002, 8'h50, 16'h0005, 8'h00, 4'h1, 4'h5});
    vecs.push_back('{"ADD",    16'h0352, 5'h00, 1'b0, PCEN,          16'h0008, 8'h05, 16'h0052, 8'h00, 4'h3, 4'h2});
    vecs.push_back('{"CMP",    16'h03B2, 5'h00, 1'b0, PCEN,          16'h0000, 8'h0B, 16'hFFB2, 8'h00, 4'h3, 4'h2});
    vecs.push_back('{"CMPI",   16'hB3F0, 5'h00, 1'b0, PCEN | IMMSEL, 16'h0000, 8'hB0, 16'hFFF0, 8'h00, 4'h3, 4'h0});
    vecs.push_back('{"MOVI",   16'hD4F0, 5'h00, 1'b0, PCEN | IMMSEL, 16'h0010, 8'hD0, 16'h00F0, 8'h00, 4'h4, 4'h0});
    vecs.push_back('{"ADDUI",  16'h6780, 5'h00, 1'b0, PCEN | IMMSEL, 16'h0080, 8'h60, 16'h0080, 8'h00, 4'h7, 4'h0});
    vecs.push_back('{"SUBI",   16'h9A80, 5'h00, 1'b0, PCEN | IMMSEL, 16'h0400, 8'h90, 16'hFF80, 8'h00, 4'hA, 4'h0});
    vecs.push_back('{"LSH",    16'h81C2, 5'h00, 1'b0, PCEN,          16'h0002, 8'h8C, 16'hFFC2, 8'h00, 4'h1, 4'h2});
    vecs.push_back('{"WAIT",   16'h0000, 5'h00, 1'b0, WAIT_CTL,      16'h0000, 8'h00, 16'h0000, 8'h00, 4'h0, 4'h0});
    vecs.push_back('{"STOR",   16'h4244, 5'h00, 1'b0, ENA | WEA | RWEN | LSC | PCEN, 16'h0000, 8'h44, 16'h0044, 8'h00, 4'h2, 4'h4});
    vecs.push_back('{"LOAD",   16'h4503, 5'h00, 1'b1, LSC | MEMSEL | PCEN, 16'h0020, 8'h40, 16'h0003, 8'h00, 4'h5, 4'h3});
    vecs.push_back('{"BEQ_t",  16'hC0FE, 5'h08, 1'b0, PCEN | PCMUX,  16'h0000, 8'hC0, 16'hFFFE, 8'hFE, 4'h0, 4'hE});
    vecs.push_back('{"BEQ_nt", 16'hC0FE, 5'h00, 1'b0, PCEN,          16'h0000, 8'hC0, 16'hFFFE, 8'hFE, 4'h0, 4'hE});
    vecs.push_back('{"BNV",    16'hCF05, 5'h1F, 1'b0, PCEN,          16'h0000, 8'hC0, 16'h0005, 8'h05, 4'hF, 4'h5});
    vecs.push_back('{"BUC",    16'hCE10, 5'h00, 1'b0, PCEN | PCMUX,  16'h0000, 8'hC0, 16'h0010, 8'h10, 4'hE, 4'h0});
    vecs.push_back('{"BLO",    16'hCA01, 5'h00, 1'b0, PCEN | PCMUX,  16'h0000, 8'hC0, 16'h0001, 8'h01, 4'hA, 4'h1});
    vecs.push_back('{"BLT",    16'hCC02, 5'h10, 1'b0, PCEN,          16'h0000, 8'hC0, 16'h0002, 8'h02, 4'hC, 4'h2});
    vecs.push_back('{"BGT",    16'hC603, 5'h10, 1'b0, PCEN | PCMUX,  16'h0000, 8'hC0, 16'h0003, 8'h03, 4'h6, 4'h3});
    vecs.push_back('{"BCS",    16'hC204, 5'h01, 1'b0, PCEN | PCMUX,  16'h0000, 8'hC0, 16'h0004, 8'h04, 4'h2, 4'h4});
    vecs.push_back('{"BHS",    16'hCB05, 5'h02, 1'b0, PCEN | PCMUX,  16'h0000, 8'hC0, 16'h0005, 8'h05, 4'hB, 4'h5});
    vecs.push_back('{"BFC",    16'hC907, 5'h04, 1'b0, PCEN,          16'h0000, 8'hC0, 16'h0007, 8'h07, 4'h9, 4'h7});
    vecs.push_back('{"BGE",    16'hCD08, 5'h00, 1'b0, PCEN,          16'h0000, 8'hC0, 16'h0008, 8'h08, 4'hD, 4'h8});
    vecs.push_back('{"BLS",    16'hC509, 5'h02, 1'b0, PCEN,          16'h0000, 8'hC0, 16'h0009, 8'h09, 4'h5, 4'h9});
    vecs.push_back('{"BNE",    16'hC10A, 5'h00, 1'b0, PCEN | PCMUX,  16'h0000, 8'hC0, 16'h000A, 8'h0A, 4'h1, 4'hA});

    repeat (2) @(negedge clock);
    checkOutput("reset ctl", 16'(getCtl()), 16'(ENA));
    checkOutput("reset wEnable", bus.wEnable, 16'h0000);
    checkOutput("reset opcode", 16'(bus.opcode), 16'h0000);
    checkOutput("reset Imm_in", bus.Imm_in, 16'h0000);
    checkOutput("reset pc_add_k", 16'(bus.pc_add_k), 16'h0000);
    reset = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Abort a LOAD in DOUT: outputs must fall back to FETCH and IR must clear at once.
    bus.instr_set = 16'h4503;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    checkOutput("abort pre wEnable", bus.wEnable, 16'h0020);
    reset = 1'b0;
    #1;
    checkOutput("abort ctl", 16'(getCtl()), 16'(ENA));
    checkOutput("abort wEnable", bus.wEnable, 16'h0000);
    checkOutput("abort Rdest", 16'(bus.Rdest_select), 16'h0000);
    @(negedge clock);
    checkOutput("abort held ctl", 16'(getCtl()), 16'(ENA));
    reset = 1'b1;

    applyStimulus(vecs[0]);
    checkOutput("final fetch ctl", 16'(getCtl()), 16'(ENA));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
